// File: rtl/subleq_pkg.sv
// SUBLEQ controller shared definitions.
// States, field widths and instruction field slices.
package subleq_pkg;

    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 8;
    localparam int INSTR_W = 24;

    localparam int A_HI = 23;
    localparam int A_LO = 16;
    localparam int B_HI = 15;
    localparam int B_LO = 8;
    localparam int C_HI = 7;
    localparam int C_LO = 0;

    typedef logic [ADDR_W-1:0]  addr_t;
    typedef logic [DATA_W-1:0]  data_t;
    typedef logic [INSTR_W-1:0] instr_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_RD_A,
        S_RD_B,
        S_EXEC,
        S_WR_B,
        S_HALT
    } state_t;

    function automatic addr_t f_a(input instr_t i);
        return i[A_HI:A_LO];
    endfunction

    function automatic addr_t f_b(input instr_t i);
        return i[B_HI:B_LO];
    endfunction

    function automatic addr_t f_c(input instr_t i);
        return i[C_HI:C_LO];
    endfunction

endpackage

// File: rtl/subleq_if.sv
// SUBLEQ memory bus: instruction fetch port and data port.
// Both ports use a req/ack handshake held until ack.
interface subleq_if;
    import subleq_pkg::*;

    logic   imem_req;
    addr_t  imem_addr;
    instr_t imem_rdata;
    logic   imem_ack;

    logic   dmem_req;
    logic   dmem_we;
    addr_t  dmem_addr;
    data_t  dmem_wdata;
    data_t  dmem_rdata;
    logic   dmem_ack;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  imem_ack,
        output dmem_req,
        output dmem_we,
        output dmem_addr,
        output dmem_wdata,
        input  dmem_rdata,
        input  dmem_ack
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output imem_ack,
        input  dmem_req,
        input  dmem_we,
        input  dmem_addr,
        input  dmem_wdata,
        output dmem_rdata,
        output dmem_ack
    );

endinterface

// File: rtl/subleq_ir.sv
// SUBLEQ instruction register.
// Loads a fetched word on enable; async clear.
module subleq_ir
    import subleq_pkg::*;
(
    input  logic   CLK,
    input  logic   RST_N,
    input  logic   en,
    input  instr_t d,
    output instr_t q
);

    // hold the current instruction until the next fetch completes
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/subleq_ctrl.sv
// SUBLEQ controller: fetch, two operand reads, subtract,
// write-back and branch, one instruction at a time.
module subleq_ctrl
    import subleq_pkg::*;
#(
    parameter addr_t RESET_PC = 8'h00
) (
    input  logic     CLK,
    input  logic     RST_N,
    input  logic     start,
    output logic     busy,
    output logic     halted,
    output addr_t    pc,
    subleq_if.master bus
);

    state_t state;

    addr_t  pc_q;
    addr_t  imem_addr_q;
    addr_t  dmem_addr_q;
    logic   imem_req_q;
    logic   dmem_req_q;
    logic   dmem_we_q;
    logic   busy_q;
    logic   halted_q;

    data_t  op_a;
    data_t  op_b;
    data_t  res_q;
    instr_t ir;

    logic   ir_load;
    logic   taken;
    logic   self_loop;
    addr_t  pc_inc;
    addr_t  next_pc;

    // FETCH handshake completion captures the instruction word
    assign ir_load = (state == S_FETCH) && bus.imem_ack;

    subleq_ir u_ir (
        .CLK   (CLK),
        .RST_N (RST_N),
        .en    (ir_load),
        .d     (bus.imem_rdata),
        .q     (ir)
    );

    assign pc             = pc_q;
    assign busy           = busy_q;
    assign halted         = halted_q;
    assign bus.imem_req   = imem_req_q;
    assign bus.imem_addr  = imem_addr_q;
    assign bus.dmem_req   = dmem_req_q;
    assign bus.dmem_we    = dmem_we_q;
    assign bus.dmem_addr  = dmem_addr_q;
    assign bus.dmem_wdata = res_q;

    // branch on signed res <= 0; a taken branch to itself halts
    always_comb begin
        taken     = res_q[DATA_W-1] || (res_q == '0);
        pc_inc    = pc_q + addr_t'(1);
        next_pc   = taken ? f_c(ir) : pc_inc;
        self_loop = taken && (f_c(ir) == pc_q);
    end

    // sequencer with registered bus and status outputs
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state       <= S_IDLE;
            pc_q        <= RESET_PC;
            op_a        <= '0;
            op_b        <= '0;
            res_q       <= '0;
            imem_req_q  <= 1'b0;
            imem_addr_q <= RESET_PC;
            dmem_req_q  <= 1'b0;
            dmem_we_q   <= 1'b0;
            dmem_addr_q <= '0;
            busy_q      <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE, S_HALT: begin
                    if (start) begin
                        state       <= S_FETCH;
                        pc_q        <= RESET_PC;
                        imem_req_q  <= 1'b1;
                        imem_addr_q <= RESET_PC;
                        busy_q      <= 1'b1;
                        halted_q    <= 1'b0;
                    end
                end
                S_FETCH: begin
                    if (bus.imem_ack) begin
                        state       <= S_RD_A;
                        imem_req_q  <= 1'b0;
                        dmem_req_q  <= 1'b1;
                        dmem_we_q   <= 1'b0;
                        dmem_addr_q <= f_a(bus.imem_rdata);
                    end
                end
                S_RD_A: begin
                    if (bus.dmem_ack) begin
                        state       <= S_RD_B;
                        op_a        <= bus.dmem_rdata;
                        dmem_addr_q <= f_b(ir);
                    end
                end
                S_RD_B: begin
                    if (bus.dmem_ack) begin
                        state      <= S_EXEC;
                        op_b       <= bus.dmem_rdata;
                        dmem_req_q <= 1'b0;
                    end
                end
                S_EXEC: begin
                    state       <= S_WR_B;
                    res_q       <= op_b - op_a;
                    dmem_req_q  <= 1'b1;
                    dmem_we_q   <= 1'b1;
                    dmem_addr_q <= f_b(ir);
                end
                S_WR_B: begin
                    if (bus.dmem_ack) begin
                        dmem_req_q <= 1'b0;
                        dmem_we_q  <= 1'b0;
                        pc_q       <= next_pc;
                        if (self_loop) begin
                            state    <= S_HALT;
                            busy_q   <= 1'b0;
                            halted_q <= 1'b1;
                        end else begin
                            state       <= S_FETCH;
                            imem_req_q  <= 1'b1;
                            imem_addr_q <= next_pc;
                        end
                    end
                end
                default: begin
                    state      <= S_IDLE;
                    imem_req_q <= 1'b0;
                    dmem_req_q <= 1'b0;
                    dmem_we_q  <= 1'b0;
                    busy_q     <= 1'b0;
                    halted_q   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/subleq_ctrl.md
SUBLEQ_CTRL -- requirements
Module: subleq_ctrl

Interface
REQ-001 Clocking and reset: one clock; reset is asynchronous and active-low.
REQ-002 Parameter RESET_PC, default 8'h00: PC value loaded at reset and on each start.
REQ-003 CLK  in  1  sole clock; all state changes on its rising edge.
REQ-004 RST_N  in  1  asynchronous active-low reset.
REQ-005 start  in  1  one-cycle pulse; begins execution from RESET_PC; honoured only in IDLE or HALT.
REQ-006 busy  out  1  high in every state except IDLE and HALT.
REQ-007 halted  out  1  high only in HALT.
REQ-008 pc  out  8  current program counter.
REQ-009 imem_req / imem_addr / imem_rdata / imem_ack  out 1 / out 8 / in 24 / in 1  instruction fetch port; word = {A[23:16], B[15:8], C[7:0]}.
REQ-010 dmem_req / dmem_we / dmem_addr / dmem_wdata / dmem_rdata / dmem_ack  out 1 / out 1 / out 8 / out 8 / in 8 / in 1  data memory port.

Function
REQ-011 States: IDLE, FETCH, RD_A, RD_B, EXEC, WR_B, HALT.
REQ-012 Handshake, both ports: controller holds req and all address/data/we stable until the cycle in which ack=1; the transfer completes in that cycle; req drops the next cycle unless a new transfer follows immediately; ack while req=0 is ignored.
REQ-013 Wait states: any number of cycles with ack=0 is legal; no timeout.
REQ-014 IDLE: no req; start -> pc=RESET_PC, FETCH.
REQ-015 FETCH: imem_req=1, imem_addr=pc; on ack, IR loads imem_rdata -> RD_A.
REQ-016 RD_A: dmem read at IR.A; on ack, latch opA -> RD_B.
REQ-017 RD_B: dmem read at IR.B; on ack, latch opB -> EXEC.
REQ-018 EXEC: single cycle, no req; res = opB - opA, 8-bit two's complement, wraps modulo 256 with no overflow flag -> WR_B.
REQ-019 WR_B: dmem write, we=1, addr=IR.B, wdata=res; on ack, update pc.
REQ-020 Branch: res signed <= 0 (res[7]=1 or res=0) -> pc=IR.C; otherwise pc=pc+1, wrapping 8'hFF->8'h00.
REQ-021 Halt: branch taken with IR.C equal to the current pc (self-loop) -> HALT, pc=IR.C; otherwise -> FETCH.
REQ-022 HALT: no req; halted=1; start -> pc=RESET_PC, FETCH.
REQ-023 start in any busy state is ignored.
REQ-024 IR.A equal to IR.B is legal: result is 0, branch taken.
REQ-025 Latency with zero wait states (ack in the first req cycle): 5 cycles per instruction (FETCH, RD_A, RD_B, EXEC, WR_B).

Reset
REQ-026 RST_N low, regardless of state or outstanding transfer: state=IDLE; pc=RESET_PC; IR, opA, opB=0; imem_req, dmem_req, dmem_we=0; busy=0; halted=0.
REQ-027 An interrupted transfer is abandoned and never retried; no dmem write completes after RST_N falls.
REQ-028 First active edge after reset release: IDLE, waiting for start.

Structure
REQ-029 Shared package subleq_pkg holds: state enumeration; field widths (ADDR_W=8, DATA_W=8, INSTR_W=24); field slice positions A/B/C.
REQ-030 One sub-module, subleq_ir: 24-bit instruction latch with enable and async active-low clear; enable driven by the FETCH handshake completion.
REQ-031 Subtract, branch decision and next-pc logic stay inline in subleq_ctrl.

Verification
REQ-032 Reset then start, zero wait states; imem[0]={8'h10,8'h11,8'h05}, mem[10h]=3, mem[11h]=7 -> mem[11h]=4; pc=01; 5 cycles.
REQ-033 mem[10h]=7, mem[11h]=7, C=8'h20 -> mem[11h]=0; branch taken; pc=20h.
REQ-034 mem[10h]=8'h01, mem[11h]=8'h80 -> res=8'h7F (wrap, positive); not taken; pc=pc+1; separately pc=8'hFF not taken -> pc=8'h00.
REQ-035 Instruction at pc=05h with C=05h and res<=0 -> HALT; halted=1; busy=0; then start -> FETCH at RESET_PC.
REQ-036 3 wait cycles on every ack; start pulsed mid-run -> addresses and data held stable while waiting; correct result; start ignored.
REQ-037 RST_N asserted during WR_B with dmem_ack low -> req and we drop immediately; memory unchanged; IDLE; pc=RESET_PC.
